mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 8, giving words per cache line (power of two; index width IW = log2(LINE_WORDS)).
REQ-002 The block SHALL have parameter WORD_W, default 16, giving the data and address width.
REQ-003 The block SHALL use one clock, clk, and reset rst_n, which is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_miss  in  1  I-cache line-fill request, held until i_fill_done.
REQ-007 i_miss_addr  in  16  I-side miss byte address; low 1+IW bits ignored.
REQ-008 d_miss  in  1  D-cache line-fill request, held until d_fill_done.
REQ-009 d_miss_addr  in  16  D-side miss byte address; low 1+IW bits ignored.
REQ-010 d_wr_req  in  1  D-side single-word write-through request, held until d_wr_done.
REQ-011 d_wr_addr / d_wr_data  in  16 / 16  write address and data.
REQ-012 mem_en / mem_wr  out  1 / 1  memory access strobe / write qualifier.
REQ-013 mem_addr / mem_wdata  out  16 / 16  memory address and write data.
REQ-014 mem_rdata / mem_valid  in  16 / 1  pipelined read-return data and qualifier.
REQ-015 fill_data  out  16  mem_rdata forwarded to the filling cache.
REQ-016 i_fill_we, d_fill_we  out  1  per-word fill write enables.
REQ-017 fill_idx  out  IW  word index of the current fill word.
REQ-018 i_fill_done, d_fill_done, d_wr_done  out  1  one-cycle completion pulses.
REQ-019 busy  out  1  high whenever state is not IDLE (drives pipeline stall).

Function
REQ-020 FSM states SHALL be IDLE, WRITE, I_FILL, D_FILL.
REQ-021 In IDLE, priority SHALL be d_wr_req > d_miss > i_miss; the winner's state is entered on the next edge; no request -> stay IDLE.
REQ-022 On grant the request address SHALL be latched; requester inputs are ignored until the state returns to IDLE.
REQ-023 WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched address/data, d_wr_done=1; next state IDLE.
REQ-024 In a FILL state, issue counter k SHALL step 0..LINE_WORDS-1 one per cycle with mem_en=1, mem_wr=0, mem_addr = {base[15:1+IW], k, 1'b0}; mem_en=0 once all words are issued.
REQ-025 Each mem_valid in a FILL state SHALL assert the owner's fill_we same cycle, with fill_data=mem_rdata and fill_idx = return counter, which then increments.
REQ-026 The owner's fill_done SHALL pulse in the same cycle as the LINE_WORDS-th fill_we; next state IDLE; the return counter wraps to 0.
REQ-027 mem_valid in IDLE or WRITE SHALL be ignored (no fill_we).
REQ-028 Deassertion of a request mid-operation SHALL NOT abort it.
REQ-029 A request that is high in the cycle a done pulse issues SHALL be re-arbitrated from IDLE on the following edge (one IDLE cycle minimum between operations).
REQ-030 All memory/fill/done outputs SHALL be 0 when not actively asserted by REQ-023..026.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, clear both counters and latched address, and drive every output 0, including mid-fill; memory returns still in flight after reset release are ignored per REQ-027.

Structure
REQ-032 Package cpu_mem_pkg SHALL hold the state enum, LINE_WORDS default and WORD_W.
REQ-033 Issue/return counters SHALL be one reused sub-module, fill_counter (enable, clear, wrap flag).

Verification (memory model: read data returned with mem_valid 4 cycles after issue)
REQ-034 i_miss with addr 0x1234 -> mem_addr 0x1230,0x1232..0x123E over 8 consecutive cycles; 8 i_fill_we with fill_idx 0..7; i_fill_done on the 8th; busy for 12 cycles.
REQ-035 d_wr_req (0x0040, 0xBEEF) and i_miss asserted together -> WRITE first with mem_wr=1 and d_wr_done the same cycle; then one IDLE cycle; then I_FILL starts.
REQ-036 d_miss and i_miss asserted together -> complete D_FILL (only d_fill_we toggling) before I_FILL begins.
REQ-037 rst_n pulsed low after the 3rd fill word -> all outputs 0 immediately; late mem_valid pulses produce no fill_we; a new i_miss after release fills all 8 words cleanly.
REQ-038 i_miss deasserted during fill -> fill still completes with 8 fill_we and i_fill_done.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the I/D line-fill memory arbiter.
package cpu_mem_pkg;

    localparam int unsigned DFLT_LINE_WORDS = 8;
    localparam int unsigned DFLT_WORD_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        I_FILL = 2'd2,
        D_FILL = 2'd3
    } arbState_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/memory/fill signal bundle between the arbiter (master) and its environment (slave).
interface mem_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DFLT_LINE_WORDS,
    parameter int unsigned WORD_W     = DFLT_WORD_W
);
    localparam int unsigned IW = $clog2(LINE_WORDS);

    logic              i_miss;
    logic [WORD_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [WORD_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [WORD_W-1:0] d_wr_addr;
    logic [WORD_W-1:0] d_wr_data;

    logic              mem_en;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_valid;

    logic [WORD_W-1:0] fill_data;
    logic              i_fill_we;
    logic              d_fill_we;
    logic [IW-1:0]     fill_idx;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_done;
    logic              busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, i_fill_we, d_fill_we, fill_idx,
        output i_fill_done, d_fill_done, d_wr_done, busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, i_fill_we, d_fill_we, fill_idx,
        input  i_fill_done, d_fill_done, d_wr_done, busy
    );

endinterface

// File: rtl/fill_counter.sv
// Word counter for line fills: steps on en, synchronous clear, flags the wrap step.
module fill_counter #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 wrap_c
);
    localparam int unsigned CW = $clog2(N);

    assign wrap_c = en && (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : CW'(cnt + CW'(1));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates D-side write-through, D-line fills and I-line fills onto one pipelined memory port.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DFLT_LINE_WORDS,
    parameter int unsigned WORD_W     = DFLT_WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(LINE_WORDS);

    arbState_e         state, stateNext;
    logic [WORD_W-1:0] baseAddr, baseAddrNext;
    logic [WORD_W-1:0] wrData, wrDataNext;
    logic              issueDone, issueDoneNext;

    logic [IW-1:0]     issueIdx, retIdx;
    logic              issueEn, retEn, cntClr;
    logic              issueWrap, retWrap;

    fill_counter #(.N(LINE_WORDS)) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (issueEn),
        .clr    (cntClr),
        .cnt    (issueIdx),
        .wrap_c (issueWrap)
    );

    fill_counter #(.N(LINE_WORDS)) u_ret_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (retEn),
        .clr    (cntClr),
        .cnt    (retIdx),
        .wrap_c (retWrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baseAddr  <= '0;
            wrData    <= '0;
            issueDone <= 1'b0;
        end else begin
            state     <= stateNext;
            baseAddr  <= baseAddrNext;
            wrData    <= wrDataNext;
            issueDone <= issueDoneNext;
        end
    end

    // Next state and Moore/Mealy outputs; everything idles at zero unless an active state drives it.
    always_comb begin
        stateNext       = state;
        baseAddrNext    = baseAddr;
        wrDataNext      = wrData;
        issueDoneNext   = issueDone;
        issueEn         = 1'b0;
        retEn           = 1'b0;
        cntClr          = 1'b0;

        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fill_data   = '0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.fill_idx    = '0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        bus.d_wr_done   = 1'b0;
        bus.busy        = (state != IDLE);

        case (state)
            IDLE: begin
                cntClr        = 1'b1;
                issueDoneNext = 1'b0;
                if (bus.d_wr_req) begin
                    stateNext    = WRITE;
                    baseAddrNext = bus.d_wr_addr;
                    wrDataNext   = bus.d_wr_data;
                end else if (bus.d_miss) begin
                    stateNext    = D_FILL;
                    baseAddrNext = bus.d_miss_addr;
                end else if (bus.i_miss) begin
                    stateNext    = I_FILL;
                    baseAddrNext = bus.i_miss_addr;
                end
            end

            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = baseAddr;
                bus.mem_wdata = wrData;
                bus.d_wr_done = 1'b1;
                stateNext     = IDLE;
            end

            I_FILL, D_FILL: begin
                // Issue side runs ahead of returns; it stops once the whole line is requested.
                if (!issueDone) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {baseAddr[WORD_W-1:IW+1], issueIdx, 1'b0};
                    issueEn      = 1'b1;
                    if (issueWrap) begin
                        issueDoneNext = 1'b1;
                    end
                end
                if (bus.mem_valid) begin
                    retEn         = 1'b1;
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_idx  = retIdx;
                    if (state == I_FILL) begin
                        bus.i_fill_we   = 1'b1;
                        bus.i_fill_done = retWrap;
                    end else begin
                        bus.d_fill_we   = 1'b1;
                        bus.d_fill_done = retWrap;
                    end
                    if (retWrap) begin
                        stateNext = IDLE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: 4-cycle read-latency memory model plus issue/fill scoreboards.
module tb_mem_arbiter;
    import cpu_mem_pkg::*;

    localparam int unsigned LW  = 8;
    localparam int unsigned WW  = 16;
    localparam int unsigned IW  = 3;
    localparam int unsigned LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_arbiter_if #(.LINE_WORDS(LW), .WORD_W(WW)) bus ();

    mem_arbiter #(.LINE_WORDS(LW), .WORD_W(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] memData(input logic [WW-1:0] a);
        return WW'(a * 16'd3) ^ 16'h5A0F;
    endfunction

    // Memory: read data comes back with mem_valid LAT cycles after the issue cycle.
    logic [LAT-1:0] vPipe = '0;
    logic [WW-1:0]  aPipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        vPipe    <= {vPipe[LAT-2:0], bus.mem_en & ~bus.mem_wr};
        aPipe[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) aPipe[i] <= aPipe[i-1];
    end
    assign bus.mem_valid = vPipe[LAT-1];
    assign bus.mem_rdata = memData(aPipe[LAT-1]);

    typedef struct {
        logic          wr;
        logic [WW-1:0] addr;
        logic [WW-1:0] wdata;
    } issue_t;

    typedef struct {
        logic          isI;
        logic [IW-1:0] idx;
        logic [WW-1:0] data;
        logic          done;
    } fill_t;

    typedef struct {
        string         name;
        logic          dWr;
        logic          dMiss;
        logic          iMiss;
        logic [WW-1:0] wAddr;
        logic [WW-1:0] wData;
        logic [WW-1:0] dAddr;
        logic [WW-1:0] iAddr;
        int            expBusy;
    } vec_t;

    issue_t expIss[$];
    fill_t  expFill[$];
    vec_t   vecs[8];

    int nVec = 0;
    int nBad = 0;
    int iWeCnt = 0;
    int iDoneCnt = 0;
    int validSeen = 0;
    logic autoDropI = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] allOuts();
        return 64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
                    bus.i_fill_we, bus.d_fill_we, bus.fill_idx,
                    bus.i_fill_done, bus.d_fill_done, bus.d_wr_done, bus.busy});
    endfunction

    task automatic pushWrite(input logic [WW-1:0] a, input logic [WW-1:0] d);
        issue_t e;
        e.wr = 1'b1; e.addr = a; e.wdata = d;
        expIss.push_back(e);
    endtask

    task automatic pushFill(input logic isI, input logic [WW-1:0] a);
        issue_t ei;
        fill_t  ef;
        logic [WW-1:0] w;
        for (int k = 0; k < LW; k++) begin
            w = (a & 16'hFFF0) + WW'(2 * k);
            ei.wr = 1'b0; ei.addr = w; ei.wdata = '0;
            expIss.push_back(ei);
            ef.isI = isI; ef.idx = IW'(k); ef.data = memData(w); ef.done = (k == LW - 1);
            expFill.push_back(ef);
        end
    endtask

    // Compare this cycle's memory-side and fill-side outputs against the scoreboards.
    task automatic monitor();
        issue_t ei;
        fill_t  ef;
        if (bus.mem_en) begin
            if (expIss.size() == 0) begin
                check("spurious mem_en", 64'(bus.mem_en), 64'd0);
            end else begin
                ei = expIss.pop_front();
                check("issue {wr,addr,wdata,wr_done}",
                      64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_wr_done}),
                      64'({ei.wr, ei.addr, ei.wdata, ei.wr}));
            end
        end else begin
            check("quiet mem bus", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_wr_done}), 64'd0);
        end

        if (bus.i_fill_we || bus.d_fill_we) begin
            if (expFill.size() == 0) begin
                check("spurious fill_we", 64'({bus.i_fill_we, bus.d_fill_we}), 64'd0);
            end else begin
                ef = expFill.pop_front();
                check("fill {iwe,dwe,idx,data,idone,ddone}",
                      64'({bus.i_fill_we, bus.d_fill_we, bus.fill_idx, bus.fill_data,
                           bus.i_fill_done, bus.d_fill_done}),
                      64'({ef.isI, ~ef.isI, ef.idx, ef.data, ef.done & ef.isI, ef.done & ~ef.isI}));
            end
        end else begin
            check("quiet fill side",
                  64'({bus.fill_idx, bus.fill_data, bus.i_fill_done, bus.d_fill_done}), 64'd0);
        end

        if (bus.i_fill_we)   iWeCnt++;
        if (bus.i_fill_done) iDoneCnt++;
        if (bus.mem_valid)   validSeen++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        if (bus.d_wr_done)                bus.d_wr_req = 1'b0;
        if (bus.d_fill_done)              bus.d_miss   = 1'b0;
        if (bus.i_fill_done && autoDropI) bus.i_miss   = 1'b0;
    endtask

    task automatic waitIdle(output int busyN);
        busyN = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.busy) busyN++;
            if (!bus.busy && !bus.d_wr_req && !bus.d_miss && !bus.i_miss) begin
                check("scoreboard drained", 64'(expIss.size() + expFill.size()), 64'd0);
                return;
            end
        end
        check("timeout waiting for idle",
              64'({bus.busy, bus.d_wr_req, bus.d_miss, bus.i_miss}), 64'd0);
    endtask

    task automatic runVec(input vec_t v);
        int n;
        if (v.dWr)   pushWrite(v.wAddr, v.wData);
        if (v.dMiss) pushFill(1'b0, v.dAddr);
        if (v.iMiss) pushFill(1'b1, v.iAddr);
        bus.d_wr_addr   = v.wAddr;
        bus.d_wr_data   = v.wData;
        bus.d_miss_addr = v.dAddr;
        bus.i_miss_addr = v.iAddr;
        bus.d_wr_req    = v.dWr;
        bus.d_miss      = v.dMiss;
        bus.i_miss      = v.iMiss;
        waitIdle(n);
        check({v.name, " busy cycles"}, 64'(n), 64'(v.expBusy));
    endtask

    initial begin
        int n, t, b;

        vecs[0] = '{"i_miss 1234",   1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 12};
        vecs[1] = '{"d_wr 0040",     1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF, 16'h0000, 16'h0000, 1};
        vecs[2] = '{"d_miss ABCD",   1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 16'h0000, 12};
        vecs[3] = '{"wr+imiss",      1'b1, 1'b0, 1'b1, 16'h0042, 16'h1357, 16'h0000, 16'h0F0E, 13};
        vecs[4] = '{"dmiss+imiss",   1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h4000, 16'h8008, 24};
        vecs[5] = '{"all three",     1'b1, 1'b1, 1'b1, 16'hFFFE, 16'hA5A5, 16'h1111, 16'h2222, 25};
        vecs[6] = '{"i_miss top",    1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 12};
        vecs[7] = '{"d_miss zero",   1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h000F, 16'h0000, 12};

        bus.i_miss = 1'b0; bus.i_miss_addr = '0;
        bus.d_miss = 1'b0; bus.d_miss_addr = '0;
        bus.d_wr_req = 1'b0; bus.d_wr_addr = '0; bus.d_wr_data = '0;

        tick();
        check("outputs during reset", allOuts(), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check("idle after reset", allOuts(), 64'd0);

        for (int i = 0; i < 8; i++) begin
            runVec(vecs[i]);
            tick();
        end

        // Write wins over I-miss, then exactly one idle cycle, then the fill begins.
        pushWrite(16'h0040, 16'hBEEF);
        pushFill(1'b1, 16'h2468);
        bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF; bus.i_miss_addr = 16'h2468;
        bus.d_wr_req = 1'b1; bus.i_miss = 1'b1;
        tick();
        check("write cycle", 64'({bus.busy, bus.mem_en, bus.mem_wr, bus.d_wr_done, bus.mem_addr, bus.mem_wdata}),
              64'({4'b1111, 16'h0040, 16'hBEEF}));
        tick();
        check("gap cycle", 64'({bus.busy, bus.mem_en}), 64'd0);
        tick();
        check("first fill issue", 64'({bus.busy, bus.mem_en, bus.mem_wr, bus.mem_addr}),
              64'({3'b110, 16'h2460}));
        waitIdle(n);
        check("wr then fill busy", 64'(n), 64'd11);
        tick();

        // Request still high at done: re-arbitrated after one idle cycle.
        autoDropI = 1'b0;
        iDoneCnt = 0;
        pushFill(1'b1, 16'h0100);
        pushFill(1'b1, 16'h0100);
        bus.i_miss_addr = 16'h0100; bus.i_miss = 1'b1;
        t = 0; b = 0;
        while (iDoneCnt < 2 && t < 100) begin
            tick();
            t++;
            if (bus.busy) b++;
        end
        bus.i_miss = 1'b0;
        autoDropI = 1'b1;
        check("rearb {cycles,busy}", 64'({16'(t), 16'(b)}), 64'({16'd25, 16'd24}));
        waitIdle(n);
        tick();

        // Dropping the request mid-fill does not abort it.
        iDoneCnt = 0;
        pushFill(1'b1, 16'h5550);
        bus.i_miss_addr = 16'h5550; bus.i_miss = 1'b1;
        tick(); tick(); tick();
        bus.i_miss = 1'b0;
        waitIdle(n);
        check("drop mid-fill {busy,done}", 64'({16'(n + 3), 16'(iDoneCnt)}), 64'({16'd12, 16'd1}));
        tick();

        // Reset after the 3rd fill word; in-flight returns must be ignored.
        iWeCnt = 0;
        pushFill(1'b1, 16'h7A3C);
        bus.i_miss_addr = 16'h7A3C; bus.i_miss = 1'b1;
        for (int c = 0; c < 40 && iWeCnt < 3; c++) tick();
        check("reached 3rd fill word", 64'(iWeCnt), 64'd3);
        expIss.delete();
        expFill.delete();
        bus.i_miss = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("outputs at reset assert", allOuts(), 64'd0);
        tick();
        check("outputs held in reset", allOuts(), 64'd0);
        #2 rst_n = 1'b1;
        iWeCnt = 0;
        validSeen = 0;
        for (int c = 0; c < 8; c++) tick();
        check("late returns arrived", 64'(validSeen > 0), 64'd1);
        check("no fill_we after reset", 64'(iWeCnt), 64'd0);
        runVec('{"refill after reset", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h7A3C, 12});
        check("refill word count", 64'(iWeCnt), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
